// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Holds the fetched PC, PC+4 and instruction for the decode stage. It freezes
// on a load-use stall, squashes to a NOP on a redirect, and keeps saturating
// stall/flush event counters for the debug display.
// Every output is a flop output. This breaks the loop id_inst -> stall detector -> stall.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc4,
  input  logic [31:0]      if_inst,
  input  logic             if_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic             id_held,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A stall only counts when no flush overrides it on the same edge.
  logic stall_eff;
  assign stall_eff = stall & ~flush;

  // Decode slot update. Priority is reset, then flush, then stall, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc    <= 32'h0;
      id_pc4   <= 32'h0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
      id_held  <= 1'b0;
    end else if (flush) begin
      // PC fields keep their old values so debug still shows where the squash happened.
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
      id_held  <= 1'b0;
    end else if (stall) begin
      id_held  <= 1'b1;
    end else begin
      id_pc    <= if_pc;
      id_pc4   <= if_pc4;
      // A bubble never carries a live instruction word into decode.
      id_inst  <= if_valid ? if_inst : NOP_INST;
      id_valid <= if_valid;
      id_held  <= 1'b0;
    end
  end

  // Saturating count of edges on which the slot was held by a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_eff && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Saturating count of edges on which the slot was flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (flush && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
